ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader_pkg.sv | 16 +
 rtl/ram_burst_reader_fifo.sv | 54 +++++
 rtl/ram_burst_reader.sv | 140 ++++++++++++++
 tb/tb_ram_burst_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared types and constants for the RAM burst reader and its output FIFO.
// Latency: none (definitions only).
// Backpressure: n/a.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PW    = $clog2(FIFO_DEPTH);
  localparam int FIFO_CW    = FIFO_PW + 1;

endpackage

// File: rtl/ram_burst_reader_fifo.sv
// Four-entry synchronous FIFO buffering RAM read data ahead of the stream port.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module sync_fifo_4
  import ram_burst_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic [FIFO_CW-1:0] count,
  output logic               empty
);

  logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] count_q, count_d;

  // Pointer and occupancy update; push and pop in the same cycle leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(FIFO_PW-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(FIFO_PW-1){1'b0}}, pop};
    count_d  = count_q + {{(FIFO_CW-1){1'b0}}, push} - {{(FIFO_CW-1){1'b0}}, pop};
    head     = mem_q[rd_ptr_q];
    count    = count_q;
    empty    = (count_q == '0);
  end

  // Control state; reset empties the FIFO without touching the storage array.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Streams len consecutive RAM words (address wraps at DEPTH) out on a valid/ready port.
// Latency: first beat 3 cycles after the start cycle; one beat per cycle while m_ready is high.
// Backpressure: reads throttle so FIFO occupancy plus in-flight reads never exceeds 4.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic             ram_en,
  output logic [AW-1:0]    ram_addr,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam logic [AW:0]      ONE_BEAT   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]    ONE_ADDR   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [FIFO_CW:0] FIFO_LIMIT = (FIFO_CW+1)'(FIFO_DEPTH);

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW:0]        issue_left_q, issue_left_d;
  logic [AW:0]        beats_left_q, beats_left_d;
  logic               inflight_q, inflight_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   fifo_head;
  logic [FIFO_CW-1:0] fifo_count;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] occ_after_pop;
  logic               issue;
  logic               pop;
  logic               last_hs;

  sync_fifo_4 #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (ram_dout),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Stream and status outputs; held quiet while rst is high so nothing leaks during a reset.
  always_comb begin
    m_valid = !rst && !fifo_empty;
    m_data  = m_valid ? fifo_head : '0;
    m_last  = m_valid && (beats_left_q == ONE_BEAT);
    pop     = m_valid && m_ready;
    last_hs = pop && m_last;
    busy    = !rst && (state_q != ST_IDLE);
    done    = !rst && done_q;
  end

  // Read issue: only when the word is guaranteed a FIFO slot by the time its data arrives.
  always_comb begin
    occ_after_pop = fifo_count - {{(FIFO_CW-1){1'b0}}, pop};
    issue    = (state_q == ST_READ) &&
               (({1'b0, occ_after_pop} + {{FIFO_CW{1'b0}}, inflight_q}) < FIFO_LIMIT);
    ram_en   = !rst && issue;
    ram_addr = rst ? '0 : addr_q;
  end

  // Next-state logic: burst capture, address walk, beat counting and completion pulse.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beats_left_d = beats_left_q;
    inflight_d   = issue;
    done_d       = 1'b0;
    if (pop) begin
      beats_left_d = beats_left_q - ONE_BEAT;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = ST_READ;
            addr_d       = base_addr;
            issue_left_d = len;
            beats_left_d = len;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d       = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE_ADDR;
          issue_left_d = issue_left_q - ONE_BEAT;
          if (issue_left_q == ONE_BEAT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (last_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any buffered or in-flight burst silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench: burst reader driving a preloaded dual-port RAM model (mem[i]=i).
// Expected beats come from a queue filled with (base+k) mod DEPTH for each accepted burst.
// Outputs are sampled 1 ns after the falling edge, inputs change on the falling edge.
module tb_ram_burst_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      len;
  logic             busy, done, ram_en, m_valid, m_ready, m_last;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_dout, m_data;

  always #5 clk = ~clk;

  ram_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  // True dual-port RAM, NO_CHANGE mode: a port's output register holds during its writes.
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wea, enb, web;
  logic [WIDTH-1:0] dina, dinb, doutb;
  logic [AW-1:0]    addrb;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(i);
    end else begin
      if (ram_en && wea) mem[ram_addr] <= dina;
      if (enb && web) mem[addrb] <= dinb;
    end
    if (ram_en && !wea) ram_dout <= mem[ram_addr];
    if (enb && !web) doutb <= mem[addrb];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];
  int en_cnt, beat_cnt, last_cnt, done_cnt, miss;
  int read_hits [DEPTH];
  bit prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic prev_last;
  logic [AW-1:0] rb;
  logic [AW:0]   rl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, sample and score 1 ns later.
  task automatic step(input bit st, input logic [AW-1:0] b, input logic [AW:0] l,
                      input bit rdy, input bit r);
    int e;
    @(negedge clk);
    start = st; base_addr = b; len = l; m_ready = rdy; rst = r;
    #1;
    if (ram_en) begin
      en_cnt++;
      read_hits[ram_addr]++;
    end
    if (done) done_cnt++;
    if (prev_stall && !r) begin
      chk("hold_valid", m_valid, 1'b1);
      chk("hold_data", m_data, prev_data);
      chk("hold_last", m_last, prev_last);
    end
    if (m_valid && m_ready) begin
      chk("beat_requested", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat_data", m_data, e);
        chk("beat_last", m_last, exp_q.size() == 0);
      end
      beat_cnt++;
      if (m_last) last_cnt++;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l, input bit rdy);
    for (int k = 0; k < int'(l); k++) exp_q.push_back((int'(b) + k) % DEPTH);
    en_cnt = 0; beat_cnt = 0; last_cnt = 0; done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) read_hits[i] = 0;
    step(1'b1, b, l, rdy, 1'b0);
  endtask

  // Run until done (bounded); optionally random m_ready and stray start pulses while busy.
  task automatic wait_done(input string tag, input int max_cyc, input bit rnd, input bit poke);
    bit seen;
    bit st;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      st = poke && (exp_q.size() > 0) && ($urandom_range(0, 3) == 0);
      step(st, AW'($urandom), (AW+1)'($urandom_range(0, DEPTH)),
           rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_last_count"}, last_cnt, 1);
    chk({tag, "_idle_after"}, busy, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ram_en"}, ram_en, 1'b0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_last"}, m_last, 1'b0);
    chk({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; len = '0;
    wea = 1'b0; dina = '0; enb = 1'b0; web = 1'b0; addrb = '0; dinb = '0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    en_cnt = 0; beat_cnt = 0; last_cnt = 0; done_cnt = 0;

    // Reset: outputs quiet while rst is high and in the cycle after it falls
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check_quiet("rst_hold");
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_quiet("rst_release");

    // Basic burst with cycle-exact latency: beats in cycles 3..6, done in cycle 7
    start_burst(8'h10, 9'd4, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t1_valid", m_valid, (k >= 3) && (k < 3 + 4));
      chk("t1_busy", busy, k < 3 + 4);
      chk("t1_done", done, k == 3 + 4);
      if (k == 1) begin
        chk("t1_first_en", ram_en, 1'b1);
        chk("t1_first_addr", ram_addr, 8'h10);
      end
      if (k == 6) chk("t1_last", m_last, 1'b1);
    end
    chk("t1_beats_left", exp_q.size(), 0);
    chk("t1_reads", en_cnt, 4);

    // Address wrap at the top of the RAM
    start_burst(8'hFE, 9'd4, 1'b1);
    wait_done("t2_wrap", 40, 1'b0, 1'b0);

    // Backpressure: m_ready low for 10 cycles, reads must stall at 4 outstanding words
    start_burst(8'h00, 9'd8, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t3_stall_reads", en_cnt <= 4, 1'b1);
    chk("t3_no_beats", beat_cnt, 0);
    chk("t3_valid_held", m_valid, 1'b1);
    wait_done("t3_bp", 100, 1'b0, 1'b0);
    chk("t3_total_reads", en_cnt, 8);

    // Zero length: done next cycle, no reads, no beats, stays idle
    start_burst(8'h33, 9'd0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_done", done, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_valid", m_valid, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_done_once", done, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_reads", en_cnt, 0);
    chk("t4_beats", beat_cnt, 0);

    // Reset after the 2nd beat of a len=8 burst, then a fresh burst
    start_burst(8'h20, 9'd8, 1'b1);
    for (int k = 0; k < 20 && beat_cnt < 2; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t5_two_beats", beat_cnt, 2);
    exp_q.delete();
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t5_valid_after_rst", m_valid, 1'b0);
    chk("t5_busy_after_rst", busy, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_no_more_beats", beat_cnt, 2);
    start_burst(8'h40, 9'd2, 1'b1);
    wait_done("t5_new", 40, 1'b0, 1'b0);

    // Full depth, random m_ready, stray start pulses while busy
    rb = AW'($urandom);
    start_burst(rb, 9'(DEPTH), 1'b1);
    wait_done("t6_full", 3000, 1'b1, 1'b1);
    chk("t6_beats", beat_cnt, DEPTH);
    chk("t6_reads", en_cnt, DEPTH);
    miss = 0;
    for (int i = 0; i < DEPTH; i++) if (read_hits[i] != 1) miss++;
    chk("t6_each_addr_once", miss, 0);

    // A few short random bursts with random m_ready
    for (int n = 0; n < 4; n++) begin
      rb = AW'($urandom);
      rl = (AW+1)'($urandom_range(1, 12));
      start_burst(rb, rl, 1'($urandom_range(0, 1)));
      wait_done("t7_rand", 400, 1'b1, 1'b1);
      chk("t7_beats", beat_cnt, int'(rl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
